// File: rtl/uart_tx_parity_odd.sv
// UART-style serial transmitter with a small input FIFO.
// Frame: start(0), data MSB first, XOR parity, stop(1); one bit per clk.
module uart_tx_parity_odd #(
  parameter int DATA_BITS    = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int BREAK_CYCLES = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_BITS-1:0]               data_in,
  input  logic                               data_valid,
  output logic                               data_ready,
  input  logic                               send_break,
  output logic                               signal,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH+1);
  localparam int BCW = $clog2(DATA_BITS+1);
  localparam int KCW = $clog2(BREAK_CYCLES+1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS-1);
  localparam logic [KCW-1:0] BRK_LAST = KCW'(BREAK_CYCLES-1);
  localparam logic [CW-1:0]  FULL     = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 push;
  logic                 pop;
  logic                 empty;

  state_t               state;
  state_t               state_d;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic [BCW-1:0]       bit_cnt;
  logic [KCW-1:0]       brk_cnt;
  logic                 sig_d;

  assign empty      = (count == '0);
  assign data_ready = (count != FULL);
  assign push       = data_valid && data_ready;
  assign fifo_count = count;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // IDLE and STOP share the same exit decision; break wins over data.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    unique case (state)
      S_IDLE, S_STOP: begin
        if (send_break) begin
          state_d = S_BREAK;
        end else if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START:  state_d = S_DATA;
      S_DATA:   if (bit_cnt == BIT_LAST) state_d = S_PARITY;
      S_PARITY: state_d = S_STOP;
      S_BREAK:  if (brk_cnt == BRK_LAST) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sig_d = 1'b1;
    unique case (state_d)
      S_START:  sig_d = 1'b0;
      S_DATA:   sig_d = shift_q[DATA_BITS-1];
      S_PARITY: sig_d = par_q;
      S_BREAK:  sig_d = 1'b0;
      default:  sig_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      signal  <= 1'b1;
      shift_q <= '0;
      par_q   <= 1'b0;
      bit_cnt <= '0;
      brk_cnt <= '0;
    end else begin
      state  <= state_d;
      signal <= sig_d;
      if (pop) begin
        shift_q <= mem[rd_ptr];
        par_q   <= ^mem[rd_ptr];
      end else if (state_d == S_DATA) begin
        shift_q <= shift_q << 1;
      end
      bit_cnt <= (state == S_DATA)  ? bit_cnt + 1'b1 : '0;
      brk_cnt <= (state == S_BREAK) ? brk_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_parity_odd.sv
// Bench for uart_tx_parity_odd: directed scenarios plus a
// randomized run against a word-queue / bit-queue line model.
module tb_uart_tx_parity_odd;

  logic       clk;
  logic       reset;
  logic [3:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       send_break;
  logic       signal;
  logic       busy;
  logic [2:0] fifo_count;

  int n_tests;
  int n_fail;

  uart_tx_parity_odd #(
    .DATA_BITS(4),
    .FIFO_DEPTH(4),
    .BREAK_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .send_break(send_break),
    .signal(signal),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] frame_of(input logic [3:0] w);
    int ones;
    ones = 0;
    for (int i = 0; i < 4; i++) ones += int'((w >> i) & 4'd1);
    return {1'b0, w, 1'(ones % 2), 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    data_in    = 4'd0;
    data_valid = 1'b0;
    send_break = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (signal !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_signal: got %b want 1", signal);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy: got %b want 0", busy);
    end
    n_tests++;
    if (fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_count: got %0d want 0", fifo_count);
    end
    n_tests++;
    if (data_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready: got %b want 1", data_ready);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single(input logic [3:0] w);
    logic [6:0] f;
    f = frame_of(w);
    data_in    = w;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    n_tests++;
    if (fifo_count !== 3'd1 || signal !== 1'b1) begin
      n_fail++;
      $display("FAIL single_push: got cnt=%0d sig=%b want 1,1",
               fifo_count, signal);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      n_tests++;
      if (signal !== f[6-i] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_bit%0d w=%h: got sig=%b busy=%b want %b,1",
                 i, w, signal, busy, f[6-i]);
      end
    end
    tick();
    n_tests++;
    if (signal !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_end: got sig=%b busy=%b cnt=%0d want 1,0,0",
               signal, busy, fifo_count);
    end
  endtask

  task automatic test_back_to_back(input logic [3:0] w0,
                                   input logic [3:0] w1,
                                   input logic [3:0] w2);
    logic [3:0] ws [3];
    logic [6:0] f;
    bit exp_q[$];
    int peak;
    ws[0] = w0;
    ws[1] = w1;
    ws[2] = w2;
    peak  = 0;
    for (int k = 0; k < 3; k++) begin
      f = frame_of(ws[k]);
      for (int i = 6; i >= 0; i--) exp_q.push_back(f[i]);
    end
    for (int c = 0; c <= 21; c++) begin
      data_valid = (c < 3);
      if (c < 3) data_in = ws[c];
      tick();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (c >= 1) begin
        n_tests++;
        if (signal !== exp_q[c-1] || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_bit%0d: got sig=%b busy=%b want %b,1",
                   c - 1, signal, busy, exp_q[c-1]);
        end
      end
    end
    n_tests++;
    if (peak != 2) begin
      n_fail++;
      $display("FAIL b2b_peak: got %0d want 2", peak);
    end
    tick();
    n_tests++;
    if (signal !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_end: got sig=%b busy=%b cnt=%0d want 1,0,0",
               signal, busy, fifo_count);
    end
  endtask

  task automatic test_fifo_full();
    logic [3:0] ws [6];
    logic [6:0] f;
    bit exp_q[$];
    for (int k = 0; k < 6; k++) ws[k] = 4'($urandom);
    for (int k = 0; k < 5; k++) begin
      f = frame_of(ws[k]);
      for (int i = 6; i >= 0; i--) exp_q.push_back(f[i]);
    end
    for (int c = 0; c <= 35; c++) begin
      data_valid = (c <= 6);
      data_in    = ws[(c < 5) ? c : 5];
      if (c == 5) begin
        n_tests++;
        if (data_ready !== 1'b0 || fifo_count !== 3'd4) begin
          n_fail++;
          $display("FAIL full_ready: got rdy=%b cnt=%0d want 0,4",
                   data_ready, fifo_count);
        end
      end
      tick();
      if (c >= 1) begin
        n_tests++;
        if (signal !== exp_q[c-1]) begin
          n_fail++;
          $display("FAIL full_bit%0d: got %b want %b",
                   c - 1, signal, exp_q[c-1]);
        end
      end
    end
    data_valid = 1'b0;
    tick();
    n_tests++;
    if (signal !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL full_end: got sig=%b busy=%b cnt=%0d want 1,0,0",
               signal, busy, fifo_count);
    end
  endtask

  task automatic test_break(input logic [3:0] w, input int sb_from);
    logic [6:0] f;
    bit exp_q[$];
    f = frame_of(w);
    for (int i = 6; i >= 0; i--) exp_q.push_back(f[i]);
    repeat (8) exp_q.push_back(1'b0);
    repeat (2) exp_q.push_back(1'b1);
    for (int c = 0; c <= 17; c++) begin
      data_valid = (c == 0);
      data_in    = w;
      send_break = (c >= sb_from && c <= 8);
      tick();
      if (c >= 1) begin
        n_tests++;
        if (signal !== exp_q[c-1] || busy !== (c <= 15)) begin
          n_fail++;
          $display("FAIL break_c%0d w=%h: got sig=%b busy=%b want %b,%b",
                   c, w, signal, busy, exp_q[c-1], (c <= 15));
        end
      end
    end
    send_break = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] ws [3];
    for (int k = 0; k < 3; k++) ws[k] = 4'($urandom);
    ws[0][1] = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      data_valid = (c < 3);
      data_in    = ws[(c < 3) ? c : 2];
      tick();
    end
    data_valid = 1'b0;
    n_tests++;
    if (fifo_count !== 3'd2 || signal !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_pre: got cnt=%0d sig=%b want 2,0",
               fifo_count, signal);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (signal !== 1'b1 || fifo_count !== 3'd0 ||
        busy !== 1'b0 || data_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_async: got sig=%b cnt=%0d busy=%b rdy=%b want 1,0,0,1",
               signal, fifo_count, busy, data_ready);
    end
    tick();
    reset = 1'b0;
    tick();
    n_tests++;
    if (signal !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_after: got sig=%b busy=%b want 1,0",
               signal, busy);
    end
    test_single(4'b1001);
  endtask

  task automatic test_break_priority(input logic [3:0] w);
    logic [6:0] f;
    bit exp_q[$];
    f = frame_of(w);
    repeat (8) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    for (int i = 6; i >= 0; i--) exp_q.push_back(f[i]);
    exp_q.push_back(1'b1);
    for (int c = 0; c <= 17; c++) begin
      data_valid = (c == 0);
      data_in    = w;
      send_break = (c == 1);
      tick();
      if (c == 1) begin
        n_tests++;
        if (fifo_count !== 3'd1) begin
          n_fail++;
          $display("FAIL prio_count: got %0d want 1", fifo_count);
        end
      end
      if (c >= 1) begin
        n_tests++;
        if (signal !== exp_q[c-1]) begin
          n_fail++;
          $display("FAIL prio_c%0d: got %b want %b",
                   c, signal, exp_q[c-1]);
        end
      end
    end
    send_break = 1'b0;
    data_valid = 1'b0;
  endtask

  // Model: accepted words queue up; whenever the line has no frame
  // bits left to send, the next word's whole frame is scheduled.
  task automatic test_random(input int ncyc);
    logic [3:0] q[$];
    bit         line_q[$];
    logic [3:0] d;
    logic [3:0] w;
    logic [6:0] f;
    logic       v;
    logic       acc;
    logic       e_sig;
    logic       e_busy;
    for (int n = 0; n < ncyc; n++) begin
      v = (n < ncyc - 40) && ($urandom_range(0, 9) < 6);
      d = 4'($urandom);
      data_valid = v;
      data_in    = d;
      send_break = 1'b0;
      acc = v && (q.size() < 4);
      if (line_q.size() == 0 && q.size() != 0) begin
        w = q.pop_front();
        f = frame_of(w);
        for (int i = 6; i >= 0; i--) line_q.push_back(f[i]);
      end
      if (acc) q.push_back(d);
      if (line_q.size() != 0) begin
        e_sig  = line_q.pop_front();
        e_busy = 1'b1;
      end else begin
        e_sig  = 1'b1;
        e_busy = 1'b0;
      end
      tick();
      n_tests++;
      if (signal !== e_sig || busy !== e_busy ||
          fifo_count !== 3'(q.size()) ||
          data_ready !== (q.size() < 4)) begin
        n_fail++;
        $display("FAIL rand_n%0d: got sig=%b busy=%b cnt=%0d rdy=%b want %b,%b,%0d,%b",
                 n, signal, busy, fifo_count, data_ready,
                 e_sig, e_busy, q.size(), (q.size() < 4));
      end
    end
    data_valid = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single(4'b0101);
    repeat (3) test_single(4'($urandom));
    test_back_to_back(4'b0110, 4'b1011, 4'b0000);
    test_back_to_back(4'($urandom), 4'($urandom), 4'($urandom));
    test_fifo_full();
    test_break(4'b1111, 2);
    test_break(4'($urandom), $urandom_range(2, 8));
    test_reset_mid();
    test_break_priority(4'($urandom));
    test_random(400);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_parity_odd.md
Name: uart_tx_parity_odd

Overview:
- Serial transmitter feeding the uart_parity_odd receiver. One line bit per clk cycle; no baud divider.
- Accepts 4-bit words over a valid/ready handshake into a small FIFO.
- Serialises each word as: start(0), data bits MSB first, parity, stop(1).
- Can also drive a line break: low for a fixed number of cycles.

Parameters:
- DATA_BITS, 4, data bits per frame
- FIFO_DEPTH, 4, words buffered; power of two ≥ 2
- BREAK_CYCLES, 8, cycles the line is held low for a break

Ports:
- clk  input  1  system clock; all state changes on posedge
- reset  input  1  asynchronous, active-high; clears all state
- data_in  input  DATA_BITS  word to transmit
- data_valid  input  1  data_in valid this cycle
- data_ready  output  1  FIFO can accept a word; high when fifo_count < FIFO_DEPTH
- send_break  input  1  request break; level-sampled at frame boundaries only
- signal  output  1  serial line, registered; idle high
- busy  output  1  high when the FSM is not in IDLE
- fifo_count  output  $clog2(FIFO_DEPTH+1)  words currently buffered

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - signal=1, busy=0, fifo_count=0, data_ready=1.
  - FSM goes to IDLE; FIFO pointers cleared.
  - Reset mid-frame or mid-break aborts it; signal returns to 1 at once.
- Push: posedge with data_valid && data_ready writes data_in to the FIFO tail.
  - data_valid while data_ready=0 is ignored and the word is dropped.
  - data_ready is combinational from fifo_count only.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. signal is driven by a register updated on the edge that enters each state.
- IDLE (signal=1):
  - If send_break=1, go to BREAK. Break has priority over a non-empty FIFO.
  - Else if the FIFO is non-empty, pop the head into a shift register, compute parity, go to START.
  - Else stay in IDLE.
- START: signal=0 for 1 cycle, then DATA.
- DATA: DATA_BITS cycles; signal = shift[DATA_BITS-1], shift left each cycle. Bit counter runs 0..DATA_BITS-1.
- PARITY: signal = XOR of all data bits of the word (1 when the word has an odd number of ones). 1 cycle.
- STOP: signal=1 for 1 cycle. Then, on the exit edge:
  - send_break=1 → BREAK;
  - else FIFO non-empty → pop and go directly to START (back-to-back, no idle cycle);
  - else → IDLE.
- BREAK: signal=0 for exactly BREAK_CYCLES cycles, then IDLE, where signal=1 for at least 1 cycle before any new frame starts.
- Frame length is DATA_BITS+3 cycles (7 at default).
- Latency: a word pushed at edge k into an empty FIFO with the FSM in IDLE shows its start bit on signal after edge k+1.
- Simultaneous push and pop on one edge: fifo_count unchanged.
  - Push into a full FIFO on the same edge as a pop is not allowed; data_ready was low that cycle.
  - The freed slot is visible as data_ready=1 in the following cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH and never underflows.
- busy=1 in START, DATA, PARITY, STOP and BREAK.
- send_break asserted mid-frame has no effect until the STOP exit edge or IDLE. It is not latched; it must still be high at that edge.

Test Plan:
- Reset, push 4'b0101 → signal sequence 0,0,1,0,1,0,1 starting 1 cycle after push; busy high for 7 cycles, then signal=1, busy=0. Loop to the receiver: valid pulses, error=0.
- Push 4'b0110, 4'b1011, 4'b0000 on consecutive cycles → three contiguous 7-cycle frames with no idle gap; parity bits 0,1,0; fifo_count peaks at 2 then drains to 0.
- Push 5 words while the FSM is stalled in a frame → data_ready=0 once fifo_count=4; 6th push with data_valid=1 is dropped; exactly 5 frames are transmitted in push order.
- Hold send_break=1 during a frame of 4'b1111 → frame completes with parity 0 and stop 1, then signal=0 for exactly 8 cycles, then ≥1 cycle high. The receiver flags the break as error.
- Assert reset in the 3rd DATA cycle of a frame with 2 words queued → signal=1 and fifo_count=0 immediately; after release, a new push of 4'b1001 yields a clean frame 0,1,0,0,1,0,1.
- send_break=1 and a non-empty FIFO in IDLE on the same edge → BREAK first (8 low cycles), then the queued word transmits.
